// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - 68030 bus cycle terminator: strobe decode, wait states, DSACK/BERR
// Selected cycles end in DSACK after WAIT_STATES data-strobe clocks; unclaimed cycles end in BERR.
module bus_responder #(
  parameter int WAIT_STATES = 2,
  parameter int PORT_WIDTH  = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic       i_AS_n,
  input  logic       i_UDS_n,
  input  logic       i_LDS_n,
  input  logic       i_RW,
  input  logic       i_SEL,
  output logic [1:0] o_DSACK_n,
  output logic       o_BERR_n,
  output logic       o_OE_n,
  output logic       o_WEU_n,
  output logic       o_WEL_n
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_TOUT,
    ST_BERR
  } state_t;

  localparam logic [1:0] ACK_CODE   = (PORT_WIDTH == 32) ? 2'b00 :
                                      (PORT_WIDTH == 8)  ? 2'b10 : 2'b01;
  localparam logic [7:0] WAIT_LOAD  = 8'(WAIT_STATES);
  localparam logic [7:0] TOUT_LIMIT = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] dsack_n_q, dsack_n_d;
  logic       berr_n_q, berr_n_d;
  logic       oe_n_q, oe_n_d;
  logic       weu_n_q, weu_n_d;
  logic       wel_n_q, wel_n_d;
  logic       ds_low;

  assign ds_low = !i_UDS_n || !i_LDS_n;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dsack_n_d = dsack_n_q;
    berr_n_d  = berr_n_q;
    oe_n_d    = oe_n_q;
    weu_n_d   = weu_n_q;
    wel_n_d   = wel_n_q;
    case (state_q)
      ST_IDLE: begin
        dsack_n_d = 2'b11;
        berr_n_d  = 1'b1;
        oe_n_d    = 1'b1;
        weu_n_d   = 1'b1;
        wel_n_d   = 1'b1;
        if (!i_AS_n) begin
          if (i_SEL) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_TOUT;
            cnt_d   = 8'd1;
          end
        end
      end
      ST_WAIT: begin
        if (i_AS_n) begin
          // Abort: the CPU dropped AS before we acknowledged.
          state_d = ST_IDLE;
          oe_n_d  = 1'b1;
          weu_n_d = 1'b1;
          wel_n_d = 1'b1;
        end else begin
          oe_n_d  = !i_RW;
          weu_n_d = i_RW || i_UDS_n;
          wel_n_d = i_RW || i_LDS_n;
          // Wait states count from the data strobe so late write strobes still get full access time.
          if (ds_low) begin
            if (cnt_q == 8'd0) begin
              state_d   = ST_ACK;
              dsack_n_d = ACK_CODE;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
      end
      ST_ACK: begin
        if (i_AS_n) begin
          state_d   = ST_IDLE;
          dsack_n_d = 2'b11;
          oe_n_d    = 1'b1;
          weu_n_d   = 1'b1;
          wel_n_d   = 1'b1;
        end
      end
      ST_TOUT: begin
        if (i_AS_n) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TOUT_LIMIT) begin
          state_d  = ST_BERR;
          berr_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_BERR: begin
        if (i_AS_n) begin
          state_d  = ST_IDLE;
          berr_n_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      dsack_n_q <= 2'b11;
      berr_n_q  <= 1'b1;
      oe_n_q    <= 1'b1;
      weu_n_q   <= 1'b1;
      wel_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dsack_n_q <= dsack_n_d;
      berr_n_q  <= berr_n_d;
      oe_n_q    <= oe_n_d;
      weu_n_q   <= weu_n_d;
      wel_n_q   <= wel_n_d;
    end
  end

  assign o_DSACK_n = dsack_n_q;
  assign o_BERR_n  = berr_n_q;
  assign o_OE_n    = oe_n_q;
  assign o_WEU_n   = weu_n_q;
  assign o_WEL_n   = wel_n_q;

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - scoreboard bench for bus_responder across four parameter builds
// Expected words are {DSACK1, DSACK0, BERR, OE, WEU, WEL} after each clock edge.
module tb_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, as_n_v, uds_n, lds_n, rw, sel;
  int         tgt;
  logic [3:0] as_bus;
  logic [1:0] dsack [4];
  logic       berr [4];
  logic       oe [4];
  logic       weu [4];
  logic       wel [4];

  // Only the targeted build sees AS; the others sit idle.
  always_comb begin
    for (int k = 0; k < 4; k++) as_bus[k] = (tgt == k) ? as_n_v : 1'b1;
  end

  bus_responder #(.WAIT_STATES(2), .PORT_WIDTH(16), .TIMEOUT(4)) dut0 (
    .i_CLK(clk), .i_RESET(rst), .i_AS_n(as_bus[0]), .i_UDS_n(uds_n), .i_LDS_n(lds_n),
    .i_RW(rw), .i_SEL(sel), .o_DSACK_n(dsack[0]), .o_BERR_n(berr[0]), .o_OE_n(oe[0]),
    .o_WEU_n(weu[0]), .o_WEL_n(wel[0]));
  bus_responder #(.WAIT_STATES(0), .PORT_WIDTH(16), .TIMEOUT(64)) dut1 (
    .i_CLK(clk), .i_RESET(rst), .i_AS_n(as_bus[1]), .i_UDS_n(uds_n), .i_LDS_n(lds_n),
    .i_RW(rw), .i_SEL(sel), .o_DSACK_n(dsack[1]), .o_BERR_n(berr[1]), .o_OE_n(oe[1]),
    .o_WEU_n(weu[1]), .o_WEL_n(wel[1]));
  bus_responder #(.WAIT_STATES(5), .PORT_WIDTH(32), .TIMEOUT(64)) dut2 (
    .i_CLK(clk), .i_RESET(rst), .i_AS_n(as_bus[2]), .i_UDS_n(uds_n), .i_LDS_n(lds_n),
    .i_RW(rw), .i_SEL(sel), .o_DSACK_n(dsack[2]), .o_BERR_n(berr[2]), .o_OE_n(oe[2]),
    .o_WEU_n(weu[2]), .o_WEL_n(wel[2]));
  bus_responder #(.WAIT_STATES(1), .PORT_WIDTH(8), .TIMEOUT(64)) dut3 (
    .i_CLK(clk), .i_RESET(rst), .i_AS_n(as_bus[3]), .i_UDS_n(uds_n), .i_LDS_n(lds_n),
    .i_RW(rw), .i_SEL(sel), .o_DSACK_n(dsack[3]), .o_BERR_n(berr[3]), .o_OE_n(oe[3]),
    .o_WEU_n(weu[3]), .o_WEL_n(wel[3]));

  typedef struct {
    int         dut;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [5:0] obs(input int k);
    return {dsack[k], berr[k], oe[k], weu[k], wel[k]};
  endfunction

  task automatic step(input int d, input string nm, input logic r, input logic a,
                      input logic u, input logic l, input logic w, input logic s,
                      input logic [5:0] e);
    vec_t v;
    tgt = d; rst = r; as_n_v = a; uds_n = u; lds_n = l; rw = w; sel = s;
    v.dut = d; v.exp = e; v.name = nm;
    sb.push_back(v);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin : mon
      vec_t       v;
      logic [5:0] act;
      v   = sb.pop_front();
      act = obs(v.dut);
      vectors++;
      if (act !== v.exp) begin
        miscompares++;
        $display("FAIL %s dut%0d: got %b expected %b", v.name, v.dut, act, v.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // args: dut, name, rst, as_n, uds_n, lds_n, rw, sel, expected
    step(0, "reset0", 1, 1, 1, 1, 1, 0, 6'b111111);
    step(0, "reset1", 1, 1, 1, 1, 1, 0, 6'b111111);

    // Word read, 2 wait states, 16-bit port.
    step(0, "rd_e0", 0, 0, 0, 0, 1, 1, 6'b111111);
    step(0, "rd_e1", 0, 0, 0, 0, 1, 1, 6'b111011);
    step(0, "rd_e2", 0, 0, 0, 0, 1, 1, 6'b111011);
    step(0, "rd_e3", 0, 0, 0, 0, 1, 1, 6'b011011);
    step(0, "rd_e4", 0, 0, 0, 0, 1, 1, 6'b011011);
    step(0, "rd_e5", 0, 1, 1, 1, 1, 1, 6'b111111);

    // Back-to-back word write.
    step(0, "wr_e0", 0, 0, 0, 0, 0, 1, 6'b111111);
    step(0, "wr_e1", 0, 0, 0, 0, 0, 1, 6'b111100);
    step(0, "wr_e2", 0, 0, 0, 0, 0, 1, 6'b111100);
    step(0, "wr_e3", 0, 0, 0, 0, 0, 1, 6'b011100);
    step(0, "wr_end", 0, 1, 1, 1, 0, 1, 6'b111111);

    // Unselected cycle reaching BERR, TIMEOUT=4.
    step(0, "to_e0", 0, 0, 1, 1, 1, 0, 6'b111111);
    step(0, "to_e1", 0, 0, 1, 1, 1, 0, 6'b111111);
    step(0, "to_e2", 0, 0, 1, 1, 1, 0, 6'b111111);
    step(0, "to_e3", 0, 0, 1, 1, 1, 0, 6'b111111);
    step(0, "to_e4", 0, 0, 1, 1, 1, 0, 6'b110111);
    step(0, "to_e5", 0, 0, 1, 1, 1, 0, 6'b110111);
    step(0, "to_end", 0, 1, 1, 1, 1, 0, 6'b111111);

    // Unselected cycle claimed elsewhere before the timeout.
    step(0, "tx_e0", 0, 0, 1, 1, 1, 0, 6'b111111);
    step(0, "tx_e1", 0, 0, 1, 1, 1, 0, 6'b111111);
    step(0, "tx_e2", 0, 1, 1, 1, 1, 0, 6'b111111);
    step(0, "tx_e3", 0, 1, 1, 1, 1, 0, 6'b111111);

    // Lower-byte write, zero wait states, LDS two clocks after AS.
    step(1, "lb_e0", 0, 0, 1, 1, 0, 1, 6'b111111);
    step(1, "lb_e1", 0, 0, 1, 1, 0, 1, 6'b111111);
    step(1, "lb_e2", 0, 0, 1, 1, 0, 1, 6'b111111);
    step(1, "lb_e3", 0, 0, 1, 0, 0, 1, 6'b011110);
    step(1, "lb_e4", 0, 0, 1, 0, 0, 1, 6'b011110);
    step(1, "lb_end", 0, 1, 1, 1, 0, 1, 6'b111111);

    // Upper-byte write, zero wait states.
    step(1, "ub_e0", 0, 0, 0, 1, 0, 1, 6'b111111);
    step(1, "ub_e1", 0, 0, 0, 1, 0, 1, 6'b011101);
    step(1, "ub_end", 0, 1, 1, 1, 0, 1, 6'b111111);

    // Abort with 5 wait states, then a full 32-bit cycle.
    step(2, "ab_e0", 0, 0, 0, 0, 1, 1, 6'b111111);
    step(2, "ab_e1", 0, 0, 0, 0, 1, 1, 6'b111011);
    step(2, "ab_e2", 0, 0, 0, 0, 1, 1, 6'b111011);
    step(2, "ab_e3", 0, 1, 1, 1, 1, 1, 6'b111111);
    step(2, "ab_e4", 0, 1, 1, 1, 1, 1, 6'b111111);
    step(2, "p32_e0", 0, 0, 0, 0, 1, 1, 6'b111111);
    for (int i = 1; i <= 5; i++) step(2, "p32_ws", 0, 0, 0, 0, 1, 1, 6'b111011);
    step(2, "p32_ack", 0, 0, 0, 0, 1, 1, 6'b001011);
    step(2, "p32_end", 0, 1, 1, 1, 1, 1, 6'b111111);

    // 8-bit port word write, 1 wait state.
    step(3, "p8_e0", 0, 0, 0, 0, 0, 1, 6'b111111);
    step(3, "p8_e1", 0, 0, 0, 0, 0, 1, 6'b111100);
    step(3, "p8_ack", 0, 0, 0, 0, 0, 1, 6'b101100);
    step(3, "p8_end", 0, 1, 1, 1, 0, 1, 6'b111111);

    // Reset while in ACK, then a normal read.
    step(0, "rs_e0", 0, 0, 0, 0, 1, 1, 6'b111111);
    step(0, "rs_e1", 0, 0, 0, 0, 1, 1, 6'b111011);
    step(0, "rs_e2", 0, 0, 0, 0, 1, 1, 6'b111011);
    step(0, "rs_ack", 0, 0, 0, 0, 1, 1, 6'b011011);
    step(0, "rs_rst", 1, 0, 0, 0, 1, 1, 6'b111111);
    step(0, "rs_rel", 0, 1, 1, 1, 1, 1, 6'b111111);
    step(0, "pr_e0", 0, 0, 0, 0, 1, 1, 6'b111111);
    step(0, "pr_e1", 0, 0, 0, 0, 1, 1, 6'b111011);
    step(0, "pr_e2", 0, 0, 0, 0, 1, 1, 6'b111011);
    step(0, "pr_ack", 0, 0, 0, 0, 1, 1, 6'b011011);
    step(0, "pr_end", 0, 1, 1, 1, 1, 1, 6'b111111);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
